sram_uart_tx: RTL
=================

SRAM_UART_TX -- requirements
Module: sram_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addra  input  64  byte address from the data crossbar slave port; only addra[3] decoded.
REQ-006 SHALL have port dina  input  64  write data.
REQ-007 SHALL have port douta  output  64  registered read data.
REQ-008 SHALL have port ena  input  1  access enable.
REQ-009 SHALL have port wea  input  8  byte write enables; ena=1 with wea=0 is a read.
REQ-010 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-011 Register map: word 0 (addra[3]=0) is TXDATA; word 1 (addra[3]=1) is STATUS.
REQ-012 Write to TXDATA with ena=1 and wea[0]=1 SHALL push dina[7:0] into the FIFO in the same edge; other byte lanes are ignored.
REQ-013 A push while the FIFO is full and no pop occurs that edge SHALL be dropped and set sticky STATUS.ovf.
REQ-014 A push and pop on the same edge SHALL both take effect, including when the FIFO is full.
REQ-015 STATUS bits: [0] full, [1] empty, [2] idle (FSM in IDLE and FIFO empty), [3] ovf, [15:8] FIFO occupancy count; all other bits read 0.
REQ-016 Write to STATUS with wea[0]=1 and dina[3]=1 SHALL clear ovf; if an overflow occurs on the same edge, set wins.
REQ-017 Reads SHALL have 1-cycle latency: douta updates on the edge where ena=1, wea=0; otherwise douta holds its value.
REQ-018 A TXDATA read SHALL return 0.
REQ-019 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE -> START when the FIFO is not empty: pop the head into the shift register, load the baud counter with CLK_DIV-1, and drive txd=0.
REQ-021 Each bit SHALL last exactly CLK_DIV cycles; the baud counter decrements each cycle and the bit ends at 0.
REQ-022 START -> DATA: 8 bits, LSB first, 3-bit bit index, leaving after bit 7.
REQ-023 DATA -> STOP: txd=1 for one bit time.
REQ-024 At the end of STOP: go to START with an immediate pop if the FIFO is not empty (back-to-back frames, no gap); otherwise go to IDLE.
REQ-025 Frame length SHALL be exactly 10*CLK_DIV cycles; first start bit appears on txd the cycle after the edge that pushed into an empty FIFO with the FSM idle.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be clog2(FIFO_DEPTH)+1.

Reset
REQ-027 On rst=0 asynchronously: FSM=IDLE, txd=1, FIFO empty, ovf=0, douta=0, and baud counter and bit index = 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately: txd=1 and queued data discarded.
REQ-029 Release of rst SHALL be synchronous to clk; no frame starts on the release edge.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum, STATUS bit index constants, and the default CLK_DIV.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-032 The FSM and baud counter SHALL reside in sram_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-033 Write TXDATA 0x55 -> txd: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles; idle=1 after 40 cycles.
REQ-034 Write 0xA5 then 0x3C on consecutive cycles -> two frames totalling 80 cycles with no idle gap; second frame bits are 0,0,1,1,1,1,0,0.
REQ-035 Write 6 bytes in 6 cycles while a frame is active -> 1 popped plus 4 queued, 1 dropped; STATUS reads full=1, ovf=1, count=4; STATUS write 0x8 -> ovf=0.
REQ-036 Read STATUS after reset -> douta=0x6 one cycle after the ena edge; a TXDATA read returns 0.
REQ-037 Assert rst=0 mid-DATA of frame 0xFF with 2 bytes queued -> txd=1 immediately; after release STATUS=0x6 and no frame is emitted.
REQ-038 FIFO full and a pop on the same edge as a push -> no ovf, count stays 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // STATUS register bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_IDLE    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

    localparam int unsigned DEFAULT_CLK_DIV    = 868;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and an occupancy count.
// A push into a full FIFO is only accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_uart_tx.sv
// UART transmitter behind a 64-bit SRAM-style slave port.
// Word 0 is TXDATA (write pushes a byte), word 1 is STATUS.
module sram_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addra,
    input  logic [63:0] dina,
    output logic [63:0] douta,
    input  logic        ena,
    input  logic [7:0]  wea,
    output logic        txd
);

    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    tx_state_t       state;
    tx_state_t       state_next;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            bit_done;
    logic            pop_req;
    logic            push_req;
    logic            ovf_clr;
    logic            ovf_set;
    logic            ovf;
    logic            rd_req;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [63:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{addra[63:4], addra[2:0], dina[63:8], wea[7:1]};

    assign bit_done = (baud_cnt == '0);
    assign push_req = ena && wea[0] && !addra[3];
    assign ovf_clr  = ena && wea[0] && addra[3] && dina[3];
    assign ovf_set  = push_req && fifo_full && !pop_req;
    assign rd_req   = ena && (wea == '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_req),
        .din   (dina[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_START;
            ST_START: if (bit_done) state_next = ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx == 3'd7)) state_next = ST_STOP;
            ST_STOP:  if (bit_done) state_next = fifo_empty ? ST_IDLE : ST_START;
            default:  state_next = ST_IDLE;
        endcase
    end

    // TX outputs: line level and FIFO pop (pop only ever requested when non-empty)
    always_comb begin
        pop_req = 1'b0;
        txd     = 1'b1;
        case (state)
            ST_IDLE:  pop_req = !fifo_empty;
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shift_reg[0];
            ST_STOP:  pop_req = bit_done && !fifo_empty;
            default:  txd = 1'b1;
        endcase
    end

    // Baud counter, bit index and shift register; a pop starts a fresh frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (pop_req) begin
            shift_reg <= fifo_dout;
            baud_cnt  <= BAUD_RELOAD;
            bit_idx   <= '0;
        end else if (state != ST_IDLE) begin
            if (bit_done) begin
                baud_cnt <= (state == ST_STOP) ? '0 : BAUD_RELOAD;
                if (state == ST_DATA) begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_idx   <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

    // Sticky overflow flag; a same-edge overflow wins over a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // STATUS word assembly
    always_comb begin
        status                              = '0;
        status[STAT_FULL]                   = fifo_full;
        status[STAT_EMPTY]                  = fifo_empty;
        status[STAT_IDLE]                   = (state == ST_IDLE) && fifo_empty;
        status[STAT_OVF]                    = ovf;
        status[STAT_CNT_LSB +: STAT_CNT_W]  = STAT_CNT_W'(fifo_count);
    end

    // Registered read data, held when no read is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            douta <= '0;
        end else if (rd_req) begin
            douta <= addra[3] ? status : '0;
        end
    end

endmodule
